// File: rtl/display_scheduler.sv
// Shares the seven-segment display among four note channels and scans its three digits.
// Optional DISP_SCHED_RR_EN: round-robin HomeScreen grant (default: fixed priority ch0 > ch3).
module display_scheduler #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [7:0]  BLANK_CYC = 8'd4,
  parameter logic [23:0] HOLD_CYC  = 24'd25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  screen_state,
  input  logic [19:0] note_in,
  input  logic [3:0]  note_vld,
  output logic [4:0]  disp_code,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [3:0]  AN,
  output logic [1:0]  digit_sel
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 5;
  localparam logic [CW-1:0] BLANK_CODE = 5'd31;

  typedef enum logic {IDLE, SHOW} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   code_q [NCH];
  logic [CW-1:0]   code_d [NCH];
  logic [CW-1:0]   slice  [NCH];
  logic [NCH-1:0]  pend_q, pend_d, eff_pend;
  logic [CW-1:0]   disp_q, disp_d;
  logic [1:0]      owner_q, owner_d;
  logic            busy_q;
  logic [23:0]     hold_q, hold_d;
  logic [2:0]      mode_q, mode;
  logic            home, scr_chg, gnt_any;
  logic [1:0]      focus, gnt_idx;

  logic            run_q, blank_q, blank_d;
  logic [1:0]      slot_q, slot_d, next_slot;
  logic [15:0]     cnt_q, cnt_d;
  logic [3:0]      an_q, an_d;
  logic [1:0]      dsel_q, dsel_d;

  // Rest codes (25..31) are all presented as the blank code.
  function automatic logic [CW-1:0] show_code(input logic [CW-1:0] c);
    return (c > 5'd24) ? BLANK_CODE : c;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      slice[i]  = note_in[CW*i +: CW];
      code_d[i] = note_vld[i] ? slice[i] : code_q[i];
    end
    mode     = (screen_state >= 3'd1 && screen_state <= 3'd4) ? screen_state : 3'd0;
    home     = (mode == 3'd0);
    focus    = 2'(mode - 3'd1);
    scr_chg  = (mode != mode_q);
    eff_pend = pend_q | note_vld;
  end

`ifdef DISP_SCHED_RR_EN
  logic [1:0] rr_idx;
  // Walk from owner+4 down to owner+1 so the nearest successor wins.
  always_comb begin
    gnt_any = |eff_pend;
    gnt_idx = owner_q;
    rr_idx  = owner_q;
    for (int k = NCH; k >= 1; k--) begin
      rr_idx = 2'(owner_q + 2'(k));
      if (eff_pend[rr_idx]) gnt_idx = rr_idx;
    end
  end
`else
  always_comb begin
    gnt_any = |eff_pend;
    gnt_idx = owner_q;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (eff_pend[k]) gnt_idx = 2'(k);
    end
  end
`endif

  // Ownership / hold FSM next-state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    disp_d  = disp_q;
    hold_d  = hold_q;
    pend_d  = eff_pend;
    if (scr_chg) begin
      pend_d = '0;
      if (home) begin
        state_d = IDLE;
        disp_d  = BLANK_CODE;
      end else begin
        state_d = SHOW;
        owner_d = focus;
        disp_d  = show_code(code_d[focus]);
      end
    end else if (!home) begin
      state_d       = SHOW;
      owner_d       = focus;
      disp_d        = show_code(code_d[focus]);
      pend_d[focus] = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          disp_d = BLANK_CODE;
          if (gnt_any) begin
            state_d         = SHOW;
            owner_d         = gnt_idx;
            disp_d          = show_code(code_d[gnt_idx]);
            pend_d[gnt_idx] = 1'b0;
            hold_d          = HOLD_CYC - 24'd1;
          end
        end
        SHOW: begin
          if (note_vld[owner_q]) begin
            disp_d          = show_code(slice[owner_q]);
            pend_d[owner_q] = 1'b0;
            hold_d          = HOLD_CYC - 24'd1;
          end else if (hold_q == 24'd0) begin
            if (gnt_any) begin
              owner_d         = gnt_idx;
              disp_d          = show_code(code_d[gnt_idx]);
              pend_d[gnt_idx] = 1'b0;
              hold_d          = HOLD_CYC - 24'd1;
            end else begin
              state_d = IDLE;
              disp_d  = BLANK_CODE;
            end
          end else begin
            hold_d = hold_q - 24'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Free-running digit scan; the first slot starts on the first edge after reset.
  always_comb begin
    next_slot = (slot_q == 2'd2) ? 2'd0 : 2'(slot_q + 2'd1);
    slot_d    = slot_q;
    blank_d   = blank_q;
    cnt_d     = cnt_q + 16'd1;
    if (!run_q) begin
      slot_d  = 2'd0;
      blank_d = 1'b0;
      cnt_d   = 16'd0;
    end else if (!blank_q) begin
      if (cnt_q == SCAN_DIV - 16'd1) begin
        cnt_d = 16'd0;
        if (BLANK_CYC == 8'd0) slot_d = next_slot;
        else                   blank_d = 1'b1;
      end
    end else if (cnt_q == {8'd0, BLANK_CYC} - 16'd1) begin
      cnt_d   = 16'd0;
      blank_d = 1'b0;
      slot_d  = next_slot;
    end
    an_d   = 4'b1111;
    dsel_d = 2'd3;
    if (!blank_d) begin
      an_d   = ~(4'b0001 << slot_d);
      dsel_d = slot_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NCH; i++) code_q[i] <= BLANK_CODE;
      pend_q  <= '0;
      disp_q  <= BLANK_CODE;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
      hold_q  <= 24'd0;
      mode_q  <= 3'd0;
      run_q   <= 1'b0;
      blank_q <= 1'b1;
      slot_q  <= 2'd0;
      cnt_q   <= 16'd0;
      an_q    <= 4'b1111;
      dsel_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NCH; i++) code_q[i] <= code_d[i];
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      owner_q <= owner_d;
      busy_q  <= (state_d == SHOW);
      hold_q  <= hold_d;
      mode_q  <= mode;
      run_q   <= 1'b1;
      blank_q <= blank_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      dsel_q  <= dsel_d;
    end
  end

  assign disp_code = disp_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign AN        = an_q;
  assign digit_sel = dsel_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with SCAN_DIV=4, BLANK_CYC=1, HOLD_CYC=10.
module tb_display_scheduler;

  typedef struct packed {
    logic [4:0] disp;
    logic [1:0] own;
    logic       busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  screen_state;
  logic [19:0] note_in;
  logic [3:0]  note_vld;
  logic [4:0]  disp_code;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  AN;
  logic [1:0]  digit_sel;

  int tests = 0;
  int fails = 0;
  exp_t       exp_q[$];
  logic [5:0] scan_q[$];
  exp_t       e;
  logic [5:0] s;

  display_scheduler #(
    .SCAN_DIV (16'd4),
    .BLANK_CYC(8'd1),
    .HOLD_CYC (24'd10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .screen_state(screen_state),
    .note_in     (note_in),
    .note_vld    (note_vld),
    .disp_code   (disp_code),
    .owner       (owner),
    .busy        (busy),
    .AN          (AN),
    .digit_sel   (digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] d, input logic [1:0] o, input logic b, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({d, o, b});
  endtask

  task automatic strobe(input int ch, input logic [4:0] code);
    note_in[5*ch +: 5] = code;
    note_vld[ch]       = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; screen_state = 3'd0; note_in = '0; note_vld = '0;
    #12;
    push(5'd31, 2'd0, 1'b0, 1);
    scan_q.push_back({4'b1111, 2'd3});
    e = exp_q.pop_front(); tests++;
    if ({disp_code, owner, busy} !== e) begin
      fails++;
      $display("FAIL reset_out: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
               disp_code, owner, busy, e.disp, e.own, e.busy);
    end
    s = scan_q.pop_front(); tests++;
    if ({AN, digit_sel} !== s) begin
      fails++;
      $display("FAIL reset_scan: AN/dsel=%b/%0d expected %b/%0d", AN, digit_sel, s[5:2], s[1:0]);
    end
  endtask

  task automatic test_scan();
    for (int sl = 0; sl < 3; sl++) begin
      for (int k = 0; k < 4; k++) scan_q.push_back({~(4'b0001 << sl), 2'(sl)});
      scan_q.push_back({4'b1111, 2'd3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      s = scan_q.pop_front(); tests++;
      if ({AN, digit_sel} !== s) begin
        fails++;
        $display("FAIL scan cyc %0d: AN/dsel=%b/%0d expected %b/%0d", c + 1, AN, digit_sel, s[5:2], s[1:0]);
      end
    end
  endtask

  task automatic test_home_single();
    push(5'd7, 2'd0, 1'b1, 10);
    push(5'd31, 2'd0, 1'b0, 1);
    for (int c = 0; c < 11; c++) begin
      note_vld = '0;
      if (c == 0) strobe(0, 5'd7);
      tick();
      e = exp_q.pop_front(); tests++;
      if ({disp_code, owner, busy} !== e) begin
        fails++;
        $display("FAIL home_single cyc %0d: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
                 c + 1, disp_code, owner, busy, e.disp, e.own, e.busy);
      end
    end
  endtask

  task automatic test_arb_pair();
    push(5'd4, 2'd1, 1'b1, 10);
    push(5'd12, 2'd3, 1'b1, 10);
    push(5'd31, 2'd3, 1'b0, 1);
    for (int c = 0; c < 21; c++) begin
      note_vld = '0;
      if (c == 0) begin strobe(1, 5'd4); strobe(3, 5'd12); end
      tick();
      e = exp_q.pop_front(); tests++;
      if ({disp_code, owner, busy} !== e) begin
        fails++;
        $display("FAIL arb_pair cyc %0d: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
                 c + 1, disp_code, owner, busy, e.disp, e.own, e.busy);
      end
    end
  endtask

  task automatic test_arb_order();
    push(5'd4, 2'd1, 1'b1, 10);
`ifdef DISP_SCHED_RR_EN
    push(5'd12, 2'd3, 1'b1, 10);
    push(5'd5, 2'd0, 1'b1, 10);
    push(5'd31, 2'd0, 1'b0, 1);
`else
    push(5'd5, 2'd0, 1'b1, 10);
    push(5'd12, 2'd3, 1'b1, 10);
    push(5'd31, 2'd3, 1'b0, 1);
`endif
    for (int c = 0; c < 31; c++) begin
      note_vld = '0;
      if (c == 0) begin strobe(1, 5'd4); strobe(3, 5'd12); end
      if (c == 3) strobe(0, 5'd5);
      tick();
      e = exp_q.pop_front(); tests++;
      if ({disp_code, owner, busy} !== e) begin
        fails++;
        $display("FAIL arb_order cyc %0d: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
                 c + 1, disp_code, owner, busy, e.disp, e.own, e.busy);
      end
    end
  endtask

  task automatic test_rest_code();
    push(5'd31, 2'd0, 1'b1, 1);
    push(5'd24, 2'd0, 1'b1, 10);
    push(5'd31, 2'd0, 1'b0, 1);
    for (int c = 0; c < 12; c++) begin
      note_vld = '0;
      if (c == 0) strobe(0, 5'd25);
      if (c == 1) strobe(0, 5'd24);
      tick();
      e = exp_q.pop_front(); tests++;
      if ({disp_code, owner, busy} !== e) begin
        fails++;
        $display("FAIL rest_code cyc %0d: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
                 c + 1, disp_code, owner, busy, e.disp, e.own, e.busy);
      end
    end
  endtask

  task automatic test_theme();
    push(5'd31, 2'd2, 1'b1, 1);
    push(5'd9, 2'd2, 1'b1, 3);
    push(5'd16, 2'd2, 1'b1, 1);
    for (int c = 0; c < 5; c++) begin
      note_vld = '0;
      case (c)
        0: screen_state = 3'd3;
        1: strobe(2, 5'd9);
        3: strobe(0, 5'd20);
        4: strobe(2, 5'd16);
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); tests++;
      if ({disp_code, owner, busy} !== e) begin
        fails++;
        $display("FAIL theme cyc %0d: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
                 c + 1, disp_code, owner, busy, e.disp, e.own, e.busy);
      end
    end
  endtask

  task automatic test_screen_switch();
    push(5'd31, 2'd2, 1'b0, 1);
    push(5'd3, 2'd1, 1'b1, 2);
    push(5'd20, 2'd0, 1'b1, 2);
    push(5'd31, 2'd0, 1'b0, 2);
    for (int c = 0; c < 7; c++) begin
      note_vld = '0;
      case (c)
        0: screen_state = 3'd0;
        1: strobe(1, 5'd3);
        2: strobe(2, 5'd6);
        3: screen_state = 3'd1;
        5: screen_state = 3'd0;
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); tests++;
      if ({disp_code, owner, busy} !== e) begin
        fails++;
        $display("FAIL screen_switch cyc %0d: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
                 c + 1, disp_code, owner, busy, e.disp, e.own, e.busy);
      end
    end
  endtask

  task automatic test_async_reset();
    note_vld = '0;
    strobe(0, 5'd5);
    tick();
    note_vld = '0;
    for (int k = 0; k < 4 && AN == 4'b1111; k++) tick();
    push(5'd5, 2'd0, 1'b1, 1);
    e = exp_q.pop_front(); tests++;
    if ({disp_code, owner, busy} !== e || AN === 4'b1111) begin
      fails++;
      $display("FAIL pre_reset: disp/own/busy/AN=%0d/%0d/%0b/%b expected %0d/%0d/%0b/lit",
               disp_code, owner, busy, AN, e.disp, e.own, e.busy);
    end
    #3;
    rst_n = 1'b0;
    #1;
    push(5'd31, 2'd0, 1'b0, 1);
    scan_q.push_back({4'b1111, 2'd3});
    e = exp_q.pop_front(); tests++;
    if ({disp_code, owner, busy} !== e) begin
      fails++;
      $display("FAIL async_reset_out: disp/own/busy=%0d/%0d/%0b expected %0d/%0d/%0b",
               disp_code, owner, busy, e.disp, e.own, e.busy);
    end
    s = scan_q.pop_front(); tests++;
    if ({AN, digit_sel} !== s) begin
      fails++;
      $display("FAIL async_reset_scan: AN/dsel=%b/%0d expected %b/%0d", AN, digit_sel, s[5:2], s[1:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_home_single();
    test_arb_pair();
    test_arb_order();
    test_rest_code();
    test_theme();
    test_screen_switch();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Shares the single seven-segment display among the four theme channels (main, chord, bass, beat) and sequences its digit scan. It latches per-channel note events and picks the owning channel, arbitrating in HomeScreen and locking to the focused theme otherwise. It holds each shown note for a fixed time and drives the note code to the segment decoder. It also generates the three-digit anode scan with inter-digit blanking.

## Interface
Parameters:
- SCAN_DIV, 16'd50000, clock cycles each digit is lit per scan slot (≥1)
- BLANK_CYC, 8'd4, cycles with all anodes off between slots (0 = no blanking)
- HOLD_CYC, 24'd25000000, cycles an arbitrated note stays on display in HomeScreen (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- screen_state  in  3  0 Home, 1 Main, 2 Chord, 3 Base, 4 Beat; 5–7 treated as Home
- note_in  in  20  four 5-bit note codes; ch0 [4:0] main … ch3 [19:15] beat; 0–24 note, 25–31 rest
- note_vld  in  4  per-channel one-cycle strobe, note_in slice changed
- disp_code  out  5  note code for the decoder; 31 = blank
- owner  out  2  channel owning the display
- busy  out  1  1 in SHOW state
- AN  out  4  active-low digit enables
- digit_sel  out  2  0/1/2 = digit lit, 3 = blanking

## Operation
- Per-channel latch: code_q[i] ← note_in slice and pend[i] ← 1 on note_vld[i].
- FSM has two states, IDLE and SHOW. IDLE drives disp_code = 31, busy = 0.
- HomeScreen:
  - IDLE with any pend → grant, load disp_code = code_q[g], clear pend[g], owner = g, reload hold, go to SHOW.
  - SHOW counts HOLD_CYC cycles. At expiry: grant next if any pend, else go to IDLE.
  - note_vld[owner] during SHOW: update disp_code, clear pend[owner], reload hold.
  - Grant order is round-robin starting at owner+1 (see Configuration).
- Theme screens 1–4:
  - owner = screen_state−1, FSM sits in SHOW, hold timer stopped.
  - disp_code tracks code_q[owner]; other channels' pend bits still set.
- Change of screen_state (compared to registered value) clears all pend.
  - To Home: go to IDLE.
  - To a theme: SHOW with disp_code = code_q[focused].
- A code of 25–31 is shown as 31 (blank).
- Scan cycle: slot 0 (AN 1110), blank, slot 1 (1101), blank, slot 2 (1011), blank, repeat.
  - Each slot lasts SCAN_DIV cycles; each blank lasts BLANK_CYC cycles with AN = 1111, digit_sel = 3.
  - The scan free-runs regardless of FSM state.

## Timing
- Reset values: disp_code 31, owner 0, busy 0, AN 1111, digit_sel 3, pend 0, code_q 31 each, FSM IDLE, scan counter 0.
- First slot (AN 1110) begins the cycle after reset release.
- note_vld → disp_code: 1 cycle for the owner or focused channel.
- Grant from IDLE: 1 cycle after pend is set.
- Hold expiry with pend: the new code appears on the cycle after the HOLD_CYC-th SHOW cycle, with no IDLE gap.
- Simultaneous events, same cycle:
  - note_vld on a channel being granted: the new code wins and pend stays clear.
  - Screen change with note_vld: code_q is updated, but the pend clear dominates.
- Asynchronous reset mid-hold or mid-slot returns everything to reset values immediately.

## Configuration
- DISP_SCHED_RR_EN defined: HomeScreen grant is round-robin from owner+1, wrapping 3→0.
- DISP_SCHED_RR_EN undefined: fixed priority ch0 > ch1 > ch2 > ch3. owner only indicates the current grant and does not affect ordering.

## Test plan
Test parameters: SCAN_DIV=4, BLANK_CYC=1, HOLD_CYC=10.
- Reset, then run 15 cycles → AN sequence 1110×4, 1111, 1101×4, 1111, 1011×4, 1111; digit_sel 0,3,1,3,2,3.
- Home, note_vld=0001 with ch0=7 → next cycle disp_code=7, owner=0, busy=1; after 10 cycles busy=0, disp_code=31.
- Home, same-cycle note_vld=1010 with ch1=4, ch3=12:
  - RR_EN: ch1 (4) shown for 10 cycles, then ch3 (12) with no gap.
  - Undefined: same order; then repeat with ch0 pending during the ch1 hold → ch0 is granted before ch3.
- screen_state=3 with ch2 strobing 9 then 16 → disp_code 9 then 16, each 1 cycle after its strobe; ch0 strobe has no effect on disp_code; owner=2.
- Mid-hold, switch screen_state 0→1 while ch2 is pending → pend cleared, disp_code=code_q[0]; return to 0 → IDLE, disp_code=31.
- Assert rst_n low mid-SHOW and mid-slot → AN=1111, disp_code=31, busy=0 immediately, without waiting for a clock edge.
